// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds in-flight predictions, resolves them in order, emits training updates and mispredict flushes
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pred_valid,
  input  logic                         pred_taken,
  input  logic [PC_W-1:0]              pred_pc,
  output logic                         pred_ready,
  input  logic                         res_valid,
  input  logic                         res_taken,
  output logic                         upd_valid,
  output logic                         upd_taken,
  output logic [PC_W-1:0]              upd_pc,
  output logic                         mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         res_error,
  output logic [CNT_W-1:0]             branch_cnt,
  output logic [CNT_W-1:0]             mispred_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  typedef enum logic {S_IDLE, S_TRACK} state_t;
  state_t            r_state, w_state_nxt;
  logic [AW:0]       r_wp, r_rp, w_wp_nxt, w_rp_nxt, w_occ;
  logic              r_taken [DEPTH];
  logic [PC_W-1:0]   r_pc [DEPTH];
  logic              w_full, w_empty, w_push, w_pop, w_mis, w_last;
  logic              r_upd_valid, r_upd_taken, r_mis, r_err;
  logic [PC_W-1:0]   r_upd_pc;
  logic [CNT_W-1:0]  r_bcnt, r_mcnt;

  assign w_occ      = r_wp - r_rp;
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push     = pred_valid && !w_full;
  assign w_pop      = res_valid && !w_empty;
  assign w_mis      = w_pop && (r_taken[r_rp[AW-1:0]] != res_taken);
  assign w_last     = w_occ == (AW+1)'(1);
  // A flush collapses the queue onto the post-pop read pointer, discarding any same-cycle push
  assign w_rp_nxt   = r_rp + (AW+1)'(w_pop);
  assign w_wp_nxt   = w_mis ? w_rp_nxt : r_wp + (AW+1)'(w_push);
  assign pred_ready = !w_full;
  assign occupancy  = OW'(w_occ);
  assign upd_valid  = r_upd_valid;
  assign upd_taken  = r_upd_taken;
  assign upd_pc     = r_upd_pc;
  assign mispredict = r_mis;
  assign res_error  = r_err;
  assign branch_cnt = r_bcnt;
  assign mispred_cnt = r_mcnt;

  // Control state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;

  // Next state: a push leaves IDLE; a flush or draining the last entry returns to it
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) w_state_nxt = w_push ? S_TRACK : S_IDLE;
    else w_state_nxt = (w_mis || (w_pop && !w_push && w_last)) ? S_IDLE : S_TRACK;
  end

  // FSM output: the queue is empty exactly while the control sits in IDLE
  always_comb w_empty = r_state == S_IDLE;

  // Pointers, resolution outputs, sticky error and saturating statistics
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_upd_valid <= 1'b0;
      r_upd_taken <= 1'b0;
      r_upd_pc    <= '0;
      r_mis       <= 1'b0;
      r_err       <= 1'b0;
      r_bcnt      <= '0;
      r_mcnt      <= '0;
    end else begin
      r_wp        <= w_wp_nxt;
      r_rp        <= w_rp_nxt;
      r_upd_valid <= w_pop;
      r_mis       <= w_mis;
      r_err       <= r_err || (res_valid && w_empty);
      if (w_pop) begin
        r_upd_taken <= res_taken;
        r_upd_pc    <= r_pc[r_rp[AW-1:0]];
      end
      if (w_pop && !(&r_bcnt)) r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_mis && !(&r_mcnt)) r_mcnt <= r_mcnt + CNT_W'(1);
    end

  // Queue storage needs no reset: entries are only read between the pointers
  always_ff @(posedge clk)
    if (w_push) begin
      r_taken[r_wp[AW-1:0]] <= pred_taken;
      r_pc[r_wp[AW-1:0]]    <= pred_pc;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, directed corner sequences and random traffic against a queue model
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
  logic [7:0] pred_pc = 0;
  logic pred_ready, upd_valid, upd_taken, mispredict, res_error;
  logic [7:0] upd_pc;
  logic [2:0] occupancy;
  logic [15:0] branch_cnt, mispred_cnt;
  logic s_ready, s_uv, s_ut, s_mis, s_err;
  logic [7:0] s_pc;
  logic [2:0] s_occ;
  logic [1:0] s_bc, s_mc;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .upd_valid(upd_valid),
    .upd_taken(upd_taken), .upd_pc(upd_pc), .mispredict(mispredict), .occupancy(occupancy),
    .res_error(res_error), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

  branch_resolve_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(s_ready), .res_valid(res_valid), .res_taken(res_taken), .upd_valid(s_uv),
    .upd_taken(s_ut), .upd_pc(s_pc), .mispredict(s_mis), .occupancy(s_occ),
    .res_error(s_err), .branch_cnt(s_bc), .mispred_cnt(s_mc));

  logic mq_t[$];
  logic [7:0] mq_pc[$];
  logic m_uv, m_ut, m_mis, m_err;
  logic [7:0] m_upc;
  int m_bc, m_mc;

  typedef struct {
    logic pv, pt; logic [7:0] pc; logic rv, rt;
    int occ; logic uv, mis, ready; logic [7:0] upc;
  } vec_t;
  vec_t tbl[9];

  function automatic int cap(int v, int m);
    return v > m ? m : v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mq_t.delete(); mq_pc.delete();
    m_uv = 0; m_ut = 0; m_mis = 0; m_err = 0; m_upc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_all();
    chk("ready", pred_ready, mq_t.size() != 4);
    chk("occupancy", occupancy, mq_t.size());
    chk("upd_valid", upd_valid, m_uv);
    chk("upd_taken", upd_taken, m_ut);
    chk("upd_pc", upd_pc, m_upc);
    chk("mispredict", mispredict, m_mis);
    chk("res_error", res_error, m_err);
    chk("branch_cnt", branch_cnt, cap(m_bc, 65535));
    chk("mispred_cnt", mispred_cnt, cap(m_mc, 65535));
    chk("sat_branch_cnt", s_bc, cap(m_bc, 3));
    chk("sat_mispred_cnt", s_mc, cap(m_mc, 3));
  endtask

  task automatic step(input logic pv, input logic pt, input logic [7:0] pc, input logic rv, input logic rt);
    bit push, pop, t;
    pred_valid = pv; pred_taken = pt; pred_pc = pc; res_valid = rv; res_taken = rt;
    #1 chk("ready_pre", pred_ready, mq_t.size() != 4);
    push = pv && mq_t.size() < 4;
    pop = rv && mq_t.size() > 0;
    m_uv = pop; m_mis = 0;
    if (rv && !pop) m_err = 1;
    if (pop) begin
      t = mq_t.pop_front(); m_upc = mq_pc.pop_front(); m_ut = rt;
      m_mis = t != rt; m_bc++;
      if (m_mis) begin m_mc++; mq_t.delete(); mq_pc.delete(); end
    end
    if (push && !m_mis) begin mq_t.push_back(pt); mq_pc.push_back(pc); end
    @(posedge clk); #1;
    pred_valid = 0; res_valid = 0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; pred_valid = 0; res_valid = 0;
    @(posedge clk); #3 rst = 0;
    model_reset();
    @(posedge clk); #1 check_all();
  endtask

  initial begin
    tbl[0] = '{1,1,8'h10,0,0, 1,0,0,1,8'h00};
    tbl[1] = '{1,1,8'h11,0,0, 2,0,0,1,8'h00};
    tbl[2] = '{1,0,8'h12,0,0, 3,0,0,1,8'h00};
    tbl[3] = '{1,1,8'h13,0,0, 4,0,0,0,8'h00};
    tbl[4] = '{1,0,8'h14,0,0, 4,0,0,0,8'h00};
    tbl[5] = '{0,0,8'h00,1,1, 3,1,0,1,8'h10};
    tbl[6] = '{0,0,8'h00,1,1, 2,1,0,1,8'h11};
    tbl[7] = '{0,0,8'h00,1,0, 1,1,0,1,8'h12};
    tbl[8] = '{0,0,8'h00,1,1, 0,1,0,1,8'h13};
    model_reset();
    #3 chk("rst_occ", occupancy, 0);
    chk("rst_ready", pred_ready, 1);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].pv, tbl[i].pt, tbl[i].pc, tbl[i].rv, tbl[i].rt);
      chk("tbl_occ", occupancy, tbl[i].occ);
      chk("tbl_uv", upd_valid, tbl[i].uv);
      chk("tbl_mis", mispredict, tbl[i].mis);
      chk("tbl_ready", pred_ready, tbl[i].ready);
      chk("tbl_pc", upd_pc, tbl[i].upc);
    end
    chk("tbl_bcnt", branch_cnt, 4);
    chk("tbl_mcnt", mispred_cnt, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h20 + 8'(i), 0, 0);
    step(1, 1, 8'h23, 1, 0);
    chk("flush_mis", mispredict, 1);
    chk("flush_pc", upd_pc, 8'h20);
    chk("flush_taken", upd_taken, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_mcnt", mispred_cnt, 1);
    step(0, 0, 0, 0, 0);
    chk("flush_mis_drop", mispredict, 0);
    step(0, 0, 0, 1, 1);
    chk("err_set", res_error, 1);
    chk("err_no_upd", upd_valid, 0);
    chk("err_bcnt", branch_cnt, 5);
    step(0, 0, 0, 0, 0);
    chk("err_sticky", res_error, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i[0], 8'h30 + 8'(i), 0, 0);
    step(1, 1, 8'h40, 1, 0);
    chk("fullpop_occ", occupancy, 3);
    step(1, 1, 8'h41, 0, 0);
    chk("refill_occ", occupancy, 4);
    for (int i = 0; i < 10; i++) step(1, i[1], 8'h50 + 8'(i), 1, mq_t[0]);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'h60 + 8'(i), 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("sat_bc", s_bc, 3);
    chk("sat_mc", s_mc, 3);
    chk("nosat_mc", mispred_cnt, 5);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic rt;
      rt = (mq_t.size() > 0 && $urandom_range(0, 3) != 0) ? mq_t[0] : 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1, rt);
    end
    do_reset();
    step(1, 1, 8'h70, 0, 0);
    step(1, 0, 8'h71, 0, 0);
    #3 rst = 1;
    model_reset();
    #1 check_all();
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1 check_all();
    step(1, 1, 8'h72, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("post_rst_pc", upd_pc, 8'h72);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
